// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - Sv39 page-table walker types, constants and helpers
package bp_be_pkg;

    localparam int vaddr_width_p        = 39;
    localparam int paddr_width_p        = 56;
    localparam int ptag_width_p         = 44;
    localparam int dword_width_p        = 64;
    localparam int sv39_levels_gp       = 3;
    localparam int sv39_vpn_width_gp    = 9;
    localparam int page_offset_width_gp = 12;

    typedef enum logic [2:0] {
        e_idle,
        e_send,
        e_wait,
        e_flush,
        e_done
    } bp_be_ptw_state_e;

    typedef struct packed {
        logic [9:0]              reserved;
        logic [ptag_width_p-1:0] ppn;
        logic [1:0]              rsw;
        logic                    d;
        logic                    a;
        logic                    g;
        logic                    u;
        logic                    x;
        logic                    w;
        logic                    r;
        logic                    v;
    } bp_be_sv39_pte_s;

    typedef struct packed {
        logic                     instr_miss_v;
        logic                     load_miss_v;
        logic                     store_miss_v;
        logic [vaddr_width_p-1:0] vaddr;
    } bp_be_ptw_miss_pkt_s;

    typedef struct packed {
        logic [ptag_width_p-1:0] ptag;
        logic                    gigapage;
        logic                    a;
        logic                    d;
        logic                    u;
        logic                    x;
        logic                    w;
        logic                    r;
    } bp_be_tlb_entry_s;

    typedef struct packed {
        logic                     itlb_fill_v;
        logic                     dtlb_fill_v;
        logic                     instr_page_fault_v;
        logic                     load_page_fault_v;
        logic                     store_page_fault_v;
        logic [vaddr_width_p-1:0] vaddr;
        bp_be_tlb_entry_s         entry;
    } bp_be_ptw_fill_pkt_s;

    function automatic logic [sv39_vpn_width_gp-1:0] sv39_vpn(
        input logic [vaddr_width_p-1:0] vaddr,
        input logic [1:0]               level
    );
        return vaddr[page_offset_width_gp + sv39_vpn_width_gp*int'(level) +: sv39_vpn_width_gp];
    endfunction

endpackage

// File: rtl/bp_be_pte_check.sv
// rtl/bp_be_pte_check.sv - combinational Sv39 PTE legality and permission check
module bp_be_pte_check
    import bp_be_pkg::*;
(
    input  bp_be_sv39_pte_s pte_i,
    input  logic [1:0]      level_i,
    input  logic            instr_i,
    input  logic            load_i,
    input  logic            store_i,
    input  logic [1:0]      priv_mode_i,
    input  logic            sum_i,
    input  logic            mxr_i,
    output logic            leaf_o,
    output logic            fault_o
);

    logic invalid;
    logic misaligned;
    logic perm_fault;
    logic priv_fault;
    logic ad_fault;
    logic unused_pte_bits;

    always_comb begin
        invalid    = !pte_i.v || (!pte_i.r && pte_i.w);
        leaf_o     = pte_i.r || pte_i.x;
        misaligned = ((level_i == 2'd2) && (pte_i.ppn[17:0] != '0))
                  || ((level_i == 2'd1) && (pte_i.ppn[8:0] != '0));
        perm_fault = (instr_i && !pte_i.x)
                  || (load_i && !(pte_i.r || (pte_i.x && mxr_i)))
                  || (store_i && !pte_i.w);
        // Supervisor may touch user pages for data only with SUM; never fetch from them.
        priv_fault = ((priv_mode_i == 2'd1) && pte_i.u && (instr_i || !sum_i))
                  || ((priv_mode_i == 2'd0) && !pte_i.u);
        ad_fault   = !pte_i.a || (store_i && !pte_i.d);

        if (invalid)
            fault_o = 1'b1;
        else if (!leaf_o)
            fault_o = (level_i == 2'd0);
        else
            fault_o = misaligned || perm_fault || priv_fault || ad_fault;
    end

    assign unused_pte_bits = ^{pte_i.reserved, pte_i.ppn[43:18], pte_i.rsw, pte_i.g};

endmodule

// File: rtl/bp_be_ptw_sv39.sv
// rtl/bp_be_ptw_sv39.sv - Sv39 hardware page-table walker producing TLB fill packets
module bp_be_ptw_sv39
    import bp_be_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  bp_be_ptw_miss_pkt_s      ptw_miss_pkt_i,
    input  logic [ptag_width_p-1:0]  satp_ppn_i,
    input  logic [1:0]               priv_mode_i,
    input  logic                     mstatus_sum_i,
    input  logic                     mstatus_mxr_i,
    output logic                     busy_o,
    output logic                     mem_req_v_o,
    output logic [paddr_width_p-1:0] mem_req_paddr_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_resp_v_i,
    input  logic [dword_width_p-1:0] mem_resp_data_i,
    output bp_be_ptw_fill_pkt_s      ptw_fill_pkt_o
);

    bp_be_ptw_state_e         state_q, state_d;
    logic [1:0]               level_q, level_d;
    logic [vaddr_width_p-1:0] vaddr_q, vaddr_d;
    logic [ptag_width_p-1:0]  ppn_q, ppn_d;
    logic                     instr_q, instr_d;
    logic                     load_q, load_d;
    logic                     store_q, store_d;
    logic                     fault_q, fault_d;
    bp_be_tlb_entry_s         entry_q, entry_d;

    bp_be_sv39_pte_s          pte;
    logic                     pte_leaf;
    logic                     pte_fault;
    logic [ptag_width_p-1:0]  leaf_ptag;
    logic                     fill_v;

    assign pte = mem_resp_data_i;

    bp_be_pte_check pte_check (
        .pte_i       (pte),
        .level_i     (level_q),
        .instr_i     (instr_q),
        .load_i      (load_q),
        .store_i     (store_q),
        .priv_mode_i (priv_mode_i),
        .sum_i       (mstatus_sum_i),
        .mxr_i       (mstatus_mxr_i),
        .leaf_o      (pte_leaf),
        .fault_o     (pte_fault)
    );

    // Superpages take their low PPN fields from the faulting virtual address.
    always_comb begin
        case (level_q)
            2'd2:    leaf_ptag = {pte.ppn[43:18], vaddr_q[29:12]};
            2'd1:    leaf_ptag = {pte.ppn[43:9], vaddr_q[20:12]};
            default: leaf_ptag = pte.ppn;
        endcase
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        vaddr_d = vaddr_q;
        ppn_d   = ppn_q;
        instr_d = instr_q;
        load_d  = load_q;
        store_d = store_q;
        fault_d = fault_q;
        entry_d = entry_q;
        case (state_q)
            e_idle: begin
                if (!flush_i && (ptw_miss_pkt_i.instr_miss_v || ptw_miss_pkt_i.load_miss_v
                                 || ptw_miss_pkt_i.store_miss_v)) begin
                    state_d = e_send;
                    level_d = 2'(sv39_levels_gp - 1);
                    vaddr_d = ptw_miss_pkt_i.vaddr;
                    ppn_d   = satp_ppn_i;
                    instr_d = ptw_miss_pkt_i.instr_miss_v;
                    load_d  = ptw_miss_pkt_i.load_miss_v;
                    store_d = ptw_miss_pkt_i.store_miss_v;
                end
            end
            e_send: begin
                if (flush_i)
                    state_d = e_idle;
                else if (mem_req_ready_i)
                    state_d = e_wait;
            end
            e_wait: begin
                if (mem_resp_v_i) begin
                    if (flush_i) begin
                        state_d = e_idle;
                    end else if (pte_fault || pte_leaf) begin
                        state_d           = e_done;
                        fault_d           = pte_fault;
                        entry_d.ptag      = leaf_ptag;
                        entry_d.gigapage  = (level_q == 2'd2);
                        entry_d.a         = pte.a;
                        entry_d.d         = pte.d;
                        entry_d.u         = pte.u;
                        entry_d.x         = pte.x;
                        entry_d.w         = pte.w;
                        entry_d.r         = pte.r;
                    end else begin
                        state_d = e_send;
                        ppn_d   = pte.ppn;
                        level_d = level_q - 2'd1;
                    end
                end else if (flush_i) begin
                    state_d = e_flush;
                end
            end
            e_flush: begin
                if (mem_resp_v_i)
                    state_d = e_idle;
            end
            e_done:  state_d = e_idle;
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            level_q <= '0;
            vaddr_q <= '0;
            ppn_q   <= '0;
            instr_q <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            fault_q <= 1'b0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            vaddr_q <= vaddr_d;
            ppn_q   <= ppn_d;
            instr_q <= instr_d;
            load_q  <= load_d;
            store_q <= store_d;
            fault_q <= fault_d;
            entry_q <= entry_d;
        end
    end

    assign busy_o          = (state_q != e_idle);
    assign mem_req_v_o     = (state_q == e_send) && !flush_i;
    assign mem_req_paddr_o = {ppn_q, sv39_vpn(vaddr_q, level_q), 3'b000};
    assign fill_v          = (state_q == e_done) && !flush_i;

    always_comb begin
        ptw_fill_pkt_o                    = '0;
        ptw_fill_pkt_o.itlb_fill_v        = fill_v && !fault_q && instr_q;
        ptw_fill_pkt_o.dtlb_fill_v        = fill_v && !fault_q && (load_q || store_q);
        ptw_fill_pkt_o.instr_page_fault_v = fill_v && fault_q && instr_q;
        ptw_fill_pkt_o.load_page_fault_v  = fill_v && fault_q && load_q;
        ptw_fill_pkt_o.store_page_fault_v = fill_v && fault_q && store_q;
        ptw_fill_pkt_o.vaddr              = vaddr_q;
        ptw_fill_pkt_o.entry              = entry_q;
    end

endmodule
